// File: rtl/data_memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_access_stage
//  Description : Memory-access stage of a 5-stage RISC-V pipeline. It sits
//                between the EX/MEM and MEM/WB pipeline registers. It issues
//                loads and stores on a request/ready data bus, aligns and
//                extends load data, and stalls upstream while an access is
//                outstanding. Misaligned or illegal accesses and bus timeouts
//                raise a one-cycle accessFault.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, reset                 : rising-edge clock, async active-high reset
//    memRead, memWrite, funct3    : decoded memory operation and size/sign
//    aluData, storeData           : effective address / ALU result, rs2 value
//    registerWriteEnable, rd,
//    writeBackFromMemoryOrAlu     : write-back controls from upstream
//    memReq, memWe, memAddr,
//    memWdata, memByteEnable      : registered data-bus request
//    memReady, memRdata           : data-bus completion and read word
//    memoryReadData               : aligned/extended load result
//    aluDataOut, rdOut,
//    registerWriteEnableOut,
//    writeBackFromMemoryOrAluOut  : write-back controls to MEM/WB
//    stall                        : hold upstream registers and PC
//    accessFault                  : one-cycle fault indication
// ============================================================================
module data_memory_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluData,
  input  logic [31:0] storeData,
  input  logic        registerWriteEnable,
  input  logic [4:0]  rd,
  input  logic        writeBackFromMemoryOrAlu,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memByteEnable,
  input  logic        memReady,
  input  logic [31:0] memRdata,
  output logic [31:0] memoryReadData,
  output logic [31:0] aluDataOut,
  output logic        registerWriteEnableOut,
  output logic [4:0]  rdOut,
  output logic        writeBackFromMemoryOrAluOut,
  output logic        stall,
  output logic        accessFault
);

  localparam logic [7:0] c_timeout_limit = TIMEOUT_CYCLES[7:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] result_q, result_d;
  logic [7:0]  count_q, count_d;
  logic        timeout_q, timeout_d;

  // --------------------------------------------------------------------------
  // Access decode
  // --------------------------------------------------------------------------
  logic        w_is_mem;
  logic        w_funct3_ok;
  logic        w_misaligned;
  logic        w_illegal;
  logic [1:0]  w_size;
  logic [3:0]  w_lanes;
  logic [31:0] w_store_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [7:0]  w_count_inc;

  assign w_is_mem = memRead | memWrite;
  assign w_size   = funct3[1:0];

  // Stores only know sb/sh/sw; loads additionally allow lbu/lhu.
  assign w_funct3_ok = memWrite ? (!funct3[2] && (funct3[1:0] != 2'b11))
                                : ((funct3 != 3'b011) && (funct3 != 3'b110) &&
                                   (funct3 != 3'b111));

  assign w_misaligned = ((w_size == 2'b10) && (aluData[1:0] != 2'b00)) ||
                        ((w_size == 2'b01) && aluData[0]);

  assign w_illegal = w_is_mem &
                     ((memRead & memWrite) | !w_funct3_ok | w_misaligned);

  always_comb begin
    w_lanes      = 4'b1111;
    w_store_word = storeData;
    case (w_size)
      2'b00: begin
        w_lanes      = 4'b0001 << aluData[1:0];
        w_store_word = {4{storeData[7:0]}};
      end
      2'b01: begin
        w_lanes      = aluData[1] ? 4'b1100 : 4'b0011;
        w_store_word = {2{storeData[15:0]}};
      end
      default: begin
        w_lanes      = 4'b1111;
        w_store_word = storeData;
      end
    endcase
  end

  // Load extraction from the returned word, using the held address/funct3.
  always_comb begin
    case (aluData[1:0])
      2'b00:   w_byte = memRdata[7:0];
      2'b01:   w_byte = memRdata[15:8];
      2'b10:   w_byte = memRdata[23:16];
      default: w_byte = memRdata[31:24];
    endcase
    w_half = aluData[1] ? memRdata[31:16] : memRdata[15:0];
    case (funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = memRdata;
    endcase
  end

  assign w_count_inc = count_q + 8'd1;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    result_d    = result_q;
    count_d     = count_q;
    timeout_d   = timeout_q;

    stall                  = 1'b0;
    accessFault            = 1'b0;
    memoryReadData         = 32'd0;
    registerWriteEnableOut = registerWriteEnable;

    case (state_q)
      ST_IDLE: begin
        if (w_is_mem) begin
          if (w_illegal) begin
            accessFault            = 1'b1;
            registerWriteEnableOut = 1'b0;
          end else begin
            // The instruction is not complete while stalled, so nothing
            // is allowed to reach the register file yet.
            stall                  = 1'b1;
            registerWriteEnableOut = 1'b0;
            mem_req_d              = 1'b1;
            mem_we_d               = memWrite;
            mem_addr_d             = {aluData[31:2], 2'b00};
            mem_wdata_d            = memWrite ? w_store_word : 32'd0;
            mem_be_d               = w_lanes;
            count_d                = 8'd0;
            timeout_d              = 1'b0;
            result_d               = 32'd0;
            state_d                = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        stall                  = 1'b1;
        registerWriteEnableOut = 1'b0;
        count_d                = w_count_inc;
        // memReady is checked first so a completion on the final allowed
        // cycle still wins over the timeout.
        if (memReady) begin
          result_d  = mem_we_q ? 32'd0 : w_load_data;
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
        end else if (w_count_inc == c_timeout_limit) begin
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        memoryReadData = result_q;
        if (timeout_q) begin
          accessFault            = 1'b1;
          registerWriteEnableOut = 1'b0;
        end
        timeout_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset abandons any access immediately: nothing stalls, faults or
    // writes back while it is held.
    if (reset) begin
      stall                  = 1'b0;
      accessFault            = 1'b0;
      memoryReadData         = 32'd0;
      registerWriteEnableOut = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      result_q    <= 32'd0;
      count_q     <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      result_q    <= result_d;
      count_q     <= count_d;
      timeout_q   <= timeout_d;
    end
  end

  assign memReq        = mem_req_q;
  assign memWe         = mem_we_q;
  assign memAddr       = mem_addr_q;
  assign memWdata      = mem_wdata_q;
  assign memByteEnable = mem_be_q;

  assign aluDataOut                  = aluData;
  assign rdOut                       = rd;
  assign writeBackFromMemoryOrAluOut = writeBackFromMemoryOrAlu;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_access_stage
//  Description : Scoreboard bench for data_memory_access_stage. Stimulus
//                pushes expected bus requests and instruction completions;
//                a negedge monitor pops and compares them when the DUT
//                raises memReq or drops stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [2:0]  funct3;
  logic [31:0] aluData, storeData;
  logic        registerWriteEnable;
  logic [4:0]  rd;
  logic        writeBackFromMemoryOrAlu;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memByteEnable;
  logic        memReady;
  logic [31:0] memRdata;
  logic [31:0] memoryReadData, aluDataOut;
  logic        registerWriteEnableOut;
  logic [4:0]  rdOut;
  logic        writeBackFromMemoryOrAluOut;
  logic        stall, accessFault;

  data_memory_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .memRead                     (memRead),
    .memWrite                    (memWrite),
    .funct3                      (funct3),
    .aluData                     (aluData),
    .storeData                   (storeData),
    .registerWriteEnable         (registerWriteEnable),
    .rd                          (rd),
    .writeBackFromMemoryOrAlu    (writeBackFromMemoryOrAlu),
    .memReq                      (memReq),
    .memWe                       (memWe),
    .memAddr                     (memAddr),
    .memWdata                    (memWdata),
    .memByteEnable               (memByteEnable),
    .memReady                    (memReady),
    .memRdata                    (memRdata),
    .memoryReadData              (memoryReadData),
    .aluDataOut                  (aluDataOut),
    .registerWriteEnableOut      (registerWriteEnableOut),
    .rdOut                       (rdOut),
    .writeBackFromMemoryOrAluOut (writeBackFromMemoryOrAluOut),
    .stall                       (stall),
    .accessFault                 (accessFault)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [4:0]  rdv;
    logic        wen;
    logic        wb;
    logic        fault;
    logic [31:0] rdata;
    int          stall_cyc;
    int          req_cyc;
  } comp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } bus_t;

  comp_t comp_q[$];
  bus_t  bus_q[$];

  int checks = 0;
  int errors = 0;

  logic        mon_en  = 1'b0;
  logic        noise   = 1'b0;
  int          lat_g   = 0;
  logic [31:0] rdata_g = 32'd0;
  logic [4:0]  rd_ctr  = 5'd5;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Memory responder: raises memReady on the lat_g-th WAIT cycle (never if 0).
  // When noise is set it also drives memReady high while no request is open.
  initial begin
    int rcnt;
    rcnt     = 0;
    memReady = 1'b0;
    memRdata = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      if (memReq) begin
        rcnt++;
        memReady = (rcnt == lat_g);
      end else begin
        rcnt     = 0;
        memReady = noise;
      end
      memRdata = rdata_g;
    end
  end

  // Monitor
  initial begin
    int    stall_cnt;
    int    req_cnt;
    logic  prev_req;
    comp_t c;
    bus_t  b;
    stall_cnt = 0;
    req_cnt   = 0;
    prev_req  = 1'b0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        stall_cnt = 0;
        req_cnt   = 0;
        prev_req  = memReq;
      end else begin
        if (memReq && !prev_req) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_bus_request", 32'd1, 32'd0);
          end else begin
            b = bus_q.pop_front();
            chk({b.name, ".memAddr"}, memAddr, b.addr);
            chk({b.name, ".memWe"}, {31'd0, memWe}, {31'd0, b.we});
            if (b.we) begin
              chk({b.name, ".memByteEnable"}, {28'd0, memByteEnable}, {28'd0, b.be});
              chk({b.name, ".memWdata"}, memWdata, b.wdata);
            end
          end
        end
        prev_req = memReq;
        if (memReq) req_cnt++;
        if (stall) begin
          stall_cnt++;
        end else begin
          if (comp_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            c = comp_q.pop_front();
            chk({c.name, ".aluDataOut"}, aluDataOut, c.alu);
            chk({c.name, ".rdOut"}, {27'd0, rdOut}, {27'd0, c.rdv});
            chk({c.name, ".regWeOut"}, {31'd0, registerWriteEnableOut}, {31'd0, c.wen});
            chk({c.name, ".wbSelOut"}, {31'd0, writeBackFromMemoryOrAluOut}, {31'd0, c.wb});
            chk({c.name, ".accessFault"}, {31'd0, accessFault}, {31'd0, c.fault});
            chk({c.name, ".memoryReadData"}, memoryReadData, c.rdata);
            chk({c.name, ".stall_cycles"}, stall_cnt, c.stall_cyc);
            chk({c.name, ".req_cycles"}, req_cnt, c.req_cyc);
          end
          stall_cnt = 0;
          req_cnt   = 0;
        end
      end
    end
  end

  // Drives one instruction, records its expectations, and waits (bounded)
  // for it to leave the stage. Called 1 time unit after a rising edge.
  task automatic run(input string nm, input logic rd_i, input logic wr_i,
                     input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] sd, input int lat,
                     input logic [31:0] rdat, input logic [31:0] exp_rdata,
                     input logic exp_wen, input logic exp_fault,
                     input int exp_stall, input int exp_req,
                     input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    comp_t c;
    bus_t  b;
    int    n;
    lat_g   = lat;
    rdata_g = rdat;
    c.name = nm; c.alu = addr; c.rdv = rd_ctr; c.wen = exp_wen; c.wb = rd_i;
    c.fault = exp_fault; c.rdata = exp_rdata;
    c.stall_cyc = exp_stall; c.req_cyc = exp_req;
    comp_q.push_back(c);
    if (exp_req > 0) begin
      b.name = nm; b.addr = {addr[31:2], 2'b00}; b.wdata = exp_wdata;
      b.be = exp_be; b.we = wr_i;
      bus_q.push_back(b);
    end
    memRead                  = rd_i;
    memWrite                 = wr_i;
    funct3                   = f3;
    aluData                  = addr;
    storeData                = sd;
    registerWriteEnable      = ~wr_i;
    rd                       = rd_ctr;
    writeBackFromMemoryOrAlu = rd_i;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (stall && n < 200);
    if (n >= 200) chk({nm, ".completion_timeout"}, 32'd1, 32'd0);
    rd_ctr = rd_ctr + 5'd1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                    = 1'b1;
    memRead                  = 1'b0;
    memWrite                 = 1'b0;
    funct3                   = 3'b000;
    aluData                  = 32'h0000CAFE;
    storeData                = 32'd0;
    registerWriteEnable      = 1'b1;
    rd                       = 5'd3;
    writeBackFromMemoryOrAlu = 1'b0;

    #12;
    chk("rst.memReq", {31'd0, memReq}, 32'd0);
    chk("rst.memWe", {31'd0, memWe}, 32'd0);
    chk("rst.memAddr", memAddr, 32'd0);
    chk("rst.memWdata", memWdata, 32'd0);
    chk("rst.memByteEnable", {28'd0, memByteEnable}, 32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.accessFault", {31'd0, accessFault}, 32'd0);
    chk("rst.memoryReadData", memoryReadData, 32'd0);
    chk("rst.regWeOut", {31'd0, registerWriteEnableOut}, 32'd0);
    chk("rst.aluDataOut", aluDataOut, 32'h0000CAFE);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    mon_en = 1'b1;

    //   name       rd wr f3      addr          store         lat rdata          exp_rdata     wen flt stl req be       wdata
    run("nop",      0, 0, 3'b000, 32'h00001234, 32'h0,        0,  32'h0,         32'h0,        1,  0,  0,  0,  4'b0000, 32'h0);
    run("lb_103",   1, 0, 3'b000, 32'h00000103, 32'h0,        1,  32'h80FFFFFF,  32'hFFFFFF80, 1,  0,  2,  1,  4'b0000, 32'h0);
    run("lbu_103",  1, 0, 3'b100, 32'h00000103, 32'h0,        1,  32'h80FFFFFF,  32'h00000080, 1,  0,  2,  1,  4'b0000, 32'h0);
    run("lb_101",   1, 0, 3'b000, 32'h00000101, 32'h0,        1,  32'h12345678,  32'h00000056, 1,  0,  2,  1,  4'b0000, 32'h0);
    run("lh_102",   1, 0, 3'b001, 32'h00000102, 32'h0,        2,  32'h80011234,  32'hFFFF8001, 1,  0,  3,  2,  4'b0000, 32'h0);
    run("lhu_100",  1, 0, 3'b101, 32'h00000100, 32'h0,        1,  32'h8001F234,  32'h0000F234, 1,  0,  2,  1,  4'b0000, 32'h0);
    noise = 1'b1;
    run("lw_noise", 1, 0, 3'b010, 32'h00000104, 32'h0,        2,  32'hDEADBEEF,  32'hDEADBEEF, 1,  0,  3,  2,  4'b0000, 32'h0);
    noise = 1'b0;
    run("sh_202",   0, 1, 3'b001, 32'h00000202, 32'h0000ABCD, 3,  32'hFFFFFFFF,  32'h0,        0,  0,  4,  3,  4'b1100, 32'hABCDABCD);
    run("sb_301",   0, 1, 3'b000, 32'h00000301, 32'h000000A5, 1,  32'hFFFFFFFF,  32'h0,        0,  0,  2,  1,  4'b0010, 32'hA5A5A5A5);
    run("sw_400",   0, 1, 3'b010, 32'h00000400, 32'h11223344, 1,  32'hFFFFFFFF,  32'h0,        0,  0,  2,  1,  4'b1111, 32'h11223344);
    run("sh_300",   0, 1, 3'b001, 32'h00000300, 32'h12345678, 1,  32'hFFFFFFFF,  32'h0,        0,  0,  2,  1,  4'b0011, 32'h56785678);
    run("lw_mis",   1, 0, 3'b010, 32'h00000101, 32'h0,        1,  32'h0,         32'h0,        0,  1,  0,  0,  4'b0000, 32'h0);
    run("lh_mis",   1, 0, 3'b001, 32'h00000103, 32'h0,        1,  32'h0,         32'h0,        0,  1,  0,  0,  4'b0000, 32'h0);
    run("sw_mis",   0, 1, 3'b010, 32'h00000102, 32'h0,        1,  32'h0,         32'h0,        0,  1,  0,  0,  4'b0000, 32'h0);
    run("rd_and_wr",1, 1, 3'b010, 32'h00000100, 32'h0,        1,  32'h0,         32'h0,        0,  1,  0,  0,  4'b0000, 32'h0);
    run("ld_f3_011",1, 0, 3'b011, 32'h00000100, 32'h0,        1,  32'h0,         32'h0,        0,  1,  0,  0,  4'b0000, 32'h0);
    run("st_f3_100",0, 1, 3'b100, 32'h00000100, 32'h0,        1,  32'h0,         32'h0,        0,  1,  0,  0,  4'b0000, 32'h0);
    run("nop2",     0, 0, 3'b000, 32'h00000077, 32'h0,        0,  32'h0,         32'h0,        1,  0,  0,  0,  4'b0000, 32'h0);
    run("lw_tmo",   1, 0, 3'b010, 32'h00000600, 32'h0,        0,  32'h0,         32'h0,        0,  1,  17, 16, 4'b0000, 32'h0);
    run("lw_last",  1, 0, 3'b010, 32'h00000604, 32'h0,        16, 32'h0BADF00D,  32'h0BADF00D, 1,  0,  17, 16, 4'b0000, 32'h0);

    // Reset during the WAIT of a load: bus request and stall drop at once.
    mon_en  = 1'b0;
    lat_g   = 0;
    memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b010;
    aluData = 32'h00000500; registerWriteEnable = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    chk("mid.memReq_before", {31'd0, memReq}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid.memReq", {31'd0, memReq}, 32'd0);
    chk("mid.stall", {31'd0, stall}, 32'd0);
    chk("mid.accessFault", {31'd0, accessFault}, 32'd0);
    chk("mid.regWeOut", {31'd0, registerWriteEnableOut}, 32'd0);
    memRead = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post.stall", {31'd0, stall}, 32'd0);
    chk("post.memReq", {31'd0, memReq}, 32'd0);
    chk("post.accessFault", {31'd0, accessFault}, 32'd0);
    mon_en = 1'b1;
    run("lbu_102",  1, 0, 3'b100, 32'h00000102, 32'h0,        1,  32'h00FF0000,  32'h000000FF, 1,  0,  2,  1,  4'b0000, 32'h0);
    mon_en = 1'b0;

    chk("queues_drained", comp_q.size() + bus_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_memory_access_stage.md
# data_memory_access_stage

Memory-access stage of the 5-stage RISC-V pipeline. It sits between the execute-to-memory pipeline register and the memory-to-writeback register. It drives a request/ready data-memory bus for loads and stores, and aligns and extends load data to 32 bits. It stalls the pipeline while a bus access is outstanding and flags misaligned, illegal or timed-out accesses.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles without memReady before the access aborts; legal range 1..255.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- memRead, input, 1: instruction is a load.
- memWrite, input, 1: instruction is a store.
- funct3, input, 3: access size/sign; 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010.
- aluData, input, 32: effective address, or ALU result for non-memory ops.
- storeData, input, 32: rs2 value for stores.
- registerWriteEnable, input, 1: write-enable passed through from upstream.
- rd, input, 5: destination register, passed through.
- writeBackFromMemoryOrAlu, input, 1: write-back select, passed through.
- memReq, output, 1: bus request, registered.
- memWe, output, 1: 1 = write, registered.
- memAddr, output, 32: word-aligned address ({aluData[31:2],2'b00}), registered.
- memWdata, output, 32: lane-replicated store data, registered.
- memByteEnable, output, 4: byte lanes, registered.
- memReady, input, 1: bus completion, sampled only in WAIT.
- memRdata, input, 32: read word, valid when memReady=1.
- memoryReadData, output, 32: aligned and extended load result.
- aluDataOut, output, 32: aluData passed through.
- registerWriteEnableOut, output, 1: gated write-enable.
- rdOut, output, 5: rd passed through.
- writeBackFromMemoryOrAluOut, output, 1: passed through.
- stall, output, 1: upstream registers and PC must hold while this is 1.
- accessFault, output, 1: one-cycle fault indication.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, no memory op: all outputs pass through combinationally; stall=0; memoryReadData=0.
- IDLE, legal access:
  - stall=1.
  - Register memAddr, memWdata, memByteEnable and memWe; set memReq=1.
  - Next state is WAIT; clear the timeout counter.
- Illegal access:
  - Conditions: memRead&memWrite; undefined funct3; lw/sw with addr[1:0]≠0; lh/lhu/sh with addr[0]≠0.
  - Response: no bus request, stall=0, accessFault=1 that cycle, registerWriteEnableOut=0; state stays IDLE.
- WAIT: stall=1, memReq held at 1, counter increments each cycle.
  - memReady=1: capture the aligned and extended load data into a result register, drop memReq, go to DONE.
  - Counter reaches TIMEOUT_CYCLES without memReady: drop memReq, set the timeout flag, go to DONE.
- DONE: stall=0.
  - memoryReadData = result register.
  - Timeout flag set: accessFault=1 and registerWriteEnableOut=0.
  - Next state is IDLE unconditionally, so the next instruction is evaluated fresh.
- Store lanes:
  - sb: byteEnable = 1<<addr[1:0]; wdata = byte replicated ×4.
  - sh: byteEnable = 0011 or 1100 by addr[1]; wdata = half replicated ×2.
  - sw: byteEnable = 1111.
- Load extract: select the byte or half by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend; lw passes the word.
- Stores: memoryReadData=0. The original registerWriteEnable passes through unchanged.
- During stall, upstream inputs are held stable. The block relies on this and does not re-latch them.

## Timing
- Reset (asynchronous): state=IDLE, memReq=0, memWe=0, memAddr=0, memWdata=0, memByteEnable=0, result register=0, counter=0, timeout flag=0.
  - While reset is high: stall=0, accessFault=0, memoryReadData=0, registerWriteEnableOut=0.
  - All other outputs pass through.
- Minimum access latency is 3 cycles: IDLE detect, one WAIT cycle with memReady=1, DONE. memReady arriving k cycles into WAIT adds k−1 cycles.
- memReady in IDLE or DONE is ignored. memRdata is only sampled on the WAIT cycle where memReady=1.
- If memReady and the timeout both occur in the same cycle, memReady wins and the access completes normally.
- Reset asserted mid-access drops memReq asynchronously. The access is abandoned, no fault is raised, and nothing is written back.
- Back-to-back accesses: DONE→IDLE→new request. The bus sees memReq low for at least one cycle (DONE) between accesses.

## Test plan
- Non-memory op, aluData=0x1234, rd=5, registerWriteEnable=1 -> same cycle: aluDataOut=0x1234, rdOut=5, registerWriteEnableOut=1, stall=0, memReq stays 0.
- lb at 0x103, memRdata=0x80FFFFFF, memReady on the first WAIT cycle -> stall=1 for 2 cycles; DONE: memoryReadData=0xFFFFFF80. Repeat as lbu -> 0x00000080.
- sh at 0x202, storeData=0x0000ABCD -> memAddr=0x200, memByteEnable=1100, memWdata=0xABCDABCD, memWe=1; memReady after 3 WAIT cycles -> stall=1 for 4 cycles total.
- lw at 0x101 -> no memReq; accessFault=1 for one cycle; registerWriteEnableOut=0; stall=0.
- lw with memReady never asserted, TIMEOUT_CYCLES=16 -> memReq high for 16 WAIT cycles, then DONE with accessFault=1 and registerWriteEnableOut=0; then IDLE.
- Assert reset during WAIT of an lw -> memReq=0 and stall=0 immediately; state=IDLE after reset releases; no fault pulse.
